// File: rtl/alu_io_pkg.sv
// Shared constants and types for the board-side ALU I/O path.
//   DATA_WIDTH / OP_WIDTH    : operand and opcode register widths
//   CLK_FREQ_HZ / DEBOUNCE_MS: board clock and button settle time
//   DEBOUNCE_CYCLES          : settle time expressed in clock cycles
//   btn_vec_t                : one bit per push-button channel
package alu_io_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned OP_WIDTH        = 6;
  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned CLK_FREQ_HZ     = 100_000_000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  typedef struct packed {
    logic clr;
    logic op;
    logic b;
    logic a;
  } btn_vec_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser + debouncer + press detector for a single push-button.
//   clk, reset : system clock, async active-high reset
//   btn_raw    : raw asynchronous button pin
//   level      : debounced button level
//   press      : registered 1-cycle pulse the cycle after level rises
module button_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Metastability chain; the input enters at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples;
  // any matching sample restarts the streak. cnt never exceeds CNT_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt_q <= '0;
    end else if (btn_s == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      level <= btn_s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Rising-edge pulse of the debounced level; releases produce nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/operand_input_controller.sv
// Loads slide-switch values into the ALU operand/opcode registers on debounced presses.
//   clk, reset  : system clock, async active-high reset
//   sw          : slide switches (static while a button is pressed)
//   btn_a/b/op  : raw buttons loading data_a / data_b / op_code
//   btn_clr     : raw button clearing all registers
//   data_a/b    : operand registers
//   op_code     : opcode register (low OP_WIDTH bits of sw)
//   load_strobe : 1-cycle pulse when any register is written or cleared
//   ready       : A, B and OP all loaded since the last reset/clear
module operand_input_controller #(
  parameter int unsigned DATA_WIDTH      = alu_io_pkg::DATA_WIDTH,
  parameter int unsigned OP_WIDTH        = alu_io_pkg::OP_WIDTH,
  parameter int unsigned SYNC_STAGES     = alu_io_pkg::SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = alu_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  btn_a,
  input  logic                  btn_b,
  input  logic                  btn_op,
  input  logic                  btn_clr,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [OP_WIDTH-1:0]   op_code,
  output logic                  load_strobe,
  output logic                  ready
);

  import alu_io_pkg::*;

  btn_vec_t   press;
  logic [3:0] level_unused;
  logic       a_ld, b_ld, op_ld;

  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk(clk), .reset(reset), .btn_raw(btn_a),   .level(level_unused[0]), .press(press.a));
  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk(clk), .reset(reset), .btn_raw(btn_b),   .level(level_unused[1]), .press(press.b));
  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
    .clk(clk), .reset(reset), .btn_raw(btn_op),  .level(level_unused[2]), .press(press.op));
  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .btn_raw(btn_clr), .level(level_unused[3]), .press(press.clr));

  // Register file update; clear overrides any simultaneous load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a      <= '0;
      data_b      <= '0;
      op_code     <= '0;
      a_ld        <= 1'b0;
      b_ld        <= 1'b0;
      op_ld       <= 1'b0;
      load_strobe <= 1'b0;
    end else begin
      load_strobe <= |press;
      if (press.clr) begin
        data_a  <= '0;
        data_b  <= '0;
        op_code <= '0;
        a_ld    <= 1'b0;
        b_ld    <= 1'b0;
        op_ld   <= 1'b0;
      end else begin
        if (press.a) begin
          data_a <= sw;
          a_ld   <= 1'b1;
        end
        if (press.b) begin
          data_b <= sw;
          b_ld   <= 1'b1;
        end
        if (press.op) begin
          op_code <= sw[OP_WIDTH-1:0];
          op_ld   <= 1'b1;
        end
      end
    end
  end

  assign ready = a_ld & b_ld & op_ld;

endmodule
